bin2bcd_7seg: RTL and testbench

//  Bus-side upstream stage of the 7-segment peripheral: accepts a 16-bit binary

---
 rtl/bin2bcd_7seg.sv | 110 +++++++++++
 tb/tb_bin2bcd_7seg.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_7seg.sv
// 16-bit binary to packed BCD converter (sequential double-dabble, 1 bit/clk) feeding the 7-seg data register.
// Build option: define BCD_SAT_EN to clamp results above 9999 to all-nines instead of wrapping mod 10^N_DIG.
module bin2bcd_7seg #(
  parameter int BIN_W = 16,
  parameter int N_DIG = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [BIN_W-1:0]   d_i,
  output logic [4*N_DIG-1:0] bcd_o,
  output logic               we_7seg_o,
  output logic               busy_o,
  output logic               ovf_o
);

  localparam int SCR_W = 4 * (N_DIG + 1);
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]         state_reg;
  logic [BIN_W-1:0]   shreg_reg;
  logic [SCR_W-1:0]   scratch_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [4*N_DIG-1:0] bcd_reg;
  logic               we_7seg_reg;
  logic               busy_reg;
  logic               ovf_reg;

  logic [SCR_W-1:0]   scratch_adj;
  logic [SCR_W-1:0]   scratch_next;
  logic [BIN_W-1:0]   shreg_next;
  logic [4*N_DIG-1:0] bcd_next;
  logic               ovf_next;

  // Add-3 correction on every digit in parallel; a digit is at most 9 here so no carry leaves it.
  genvar gi;
  generate
    for (gi = 0; gi < N_DIG + 1; gi++) begin : g_dig
      assign scratch_adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                      ? scratch_reg[4*gi +: 4] + 4'd3
                                      : scratch_reg[4*gi +: 4];
    end
  endgenerate

  assign {scratch_next, shreg_next} = {scratch_adj, shreg_reg} << 1;

  // The extra top digit only exists to detect values that do not fit in N_DIG digits.
  assign ovf_next = |scratch_reg[SCR_W-1 -: 4];

`ifdef BCD_SAT_EN
  assign bcd_next = ovf_next ? {N_DIG{4'h9}} : scratch_reg[4*N_DIG-1:0];
`else
  assign bcd_next = scratch_reg[4*N_DIG-1:0];
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      shreg_reg   <= '0;
      scratch_reg <= '0;
      cnt_reg     <= '0;
      bcd_reg     <= '0;
      we_7seg_reg <= 1'b0;
      busy_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      we_7seg_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (we_i) begin
            shreg_reg   <= d_i;
            scratch_reg <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          scratch_reg <= scratch_next;
          shreg_reg   <= shreg_next;
          cnt_reg     <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          bcd_reg     <= bcd_next;
          ovf_reg     <= ovf_next;
          we_7seg_reg <= 1'b1;
          busy_reg    <= 1'b0;
          state_reg   <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bcd_o     = bcd_reg;
  assign we_7seg_o = we_7seg_reg;
  assign busy_o    = busy_reg;
  assign ovf_o     = ovf_reg;

endmodule

// File: tb/tb_bin2bcd_7seg.sv
// Bench for bin2bcd_7seg: directed scenarios plus randomized writes checked every cycle against a timing/arithmetic model.
// Honours BCD_SAT_EN the same way as the design build.
module tb_bin2bcd_7seg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we  = 1'b0;
  logic [15:0] d   = 16'd0;
  logic [15:0] bcd;
  logic        we7;
  logic        busy;
  logic        ovf;

  int n_vec = 0;
  int n_err = 0;
  int dut_strobes = 0;
  logic chk_en = 1'b0;

  logic [15:0] edge_vals [6] = '{16'd0, 16'd9999, 16'd10000, 16'd65535, 16'd9998, 16'd10001};

  always #50 clk = ~clk;

  bin2bcd_7seg #(.BIN_W(16), .N_DIG(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (we),
    .d_i       (d),
    .bcd_o     (bcd),
    .we_7seg_o (we7),
    .busy_o    (busy),
    .ovf_o     (ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Decimal reference: returns {ovf, bcd}.
  function automatic logic [16:0] model_conv(input int unsigned v);
    int unsigned low;
    logic        o;
    logic [15:0] b;
    o   = (v > 9999);
    low = v % 10000;
    b   = {4'(low / 1000), 4'((low / 100) % 10), 4'((low / 10) % 10), 4'(low % 10)};
`ifdef BCD_SAT_EN
    if (o) b = 16'h9999;
`endif
    return {o, b};
  endfunction

  function automatic logic [15:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom_range(0, 9999));
      1:       return edge_vals[$urandom_range(0, 5)];
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  // Model: a write is taken when idle; its result appears 17 edges later for one cycle.
  logic [15:0] m_bcd, m_val;
  logic        m_ovf, m_busy, m_we, m_pend;
  longint      m_cyc, m_done;
  int          m_accepts = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_bcd  <= '0;
      m_val  <= '0;
      m_ovf  <= 1'b0;
      m_busy <= 1'b0;
      m_we   <= 1'b0;
      m_pend <= 1'b0;
      m_cyc  <= 0;
      m_done <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      m_we  <= 1'b0;
      if (m_pend && m_cyc == m_done) begin
        {m_ovf, m_bcd} <= model_conv(32'(m_val));
        m_we   <= 1'b1;
        m_busy <= 1'b0;
        m_pend <= 1'b0;
      end else if (!m_pend && we) begin
        m_pend    <= 1'b1;
        m_done    <= m_cyc + 17;
        m_val     <= d;
        m_busy    <= 1'b1;
        m_accepts <= m_accepts + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("cyc_bcd",  32'(bcd),  32'(m_bcd));
      chk("cyc_ovf",  32'(ovf),  32'(m_ovf));
      chk("cyc_busy", 32'(busy), 32'(m_busy));
      chk("cyc_we7",  32'(we7),  32'(m_we));
      if (we7 === 1'b1) dut_strobes++;
    end
  end

  task automatic send(input logic [15:0] v);
    @(negedge clk);
    we = 1'b1;
    d  = v;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic wait_strobe(input string name);
    int k;
    k = 0;
    while (we7 !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_timeout"}, 32'(k < 60), 32'd1);
  endtask

  initial begin
    #(100 * 60000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int     n, s0, a0, cycles;
    longint t1, t2;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_bcd",  32'(bcd),  32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovf",  32'(ovf),  32'h0);
    chk("rst_we7",  32'(we7),  32'h0);

    chk("model_1234",  32'(model_conv(1234)),  32'h01234);
    chk("model_0",     32'(model_conv(0)),     32'h00000);
    chk("model_9999",  32'(model_conv(9999)),  32'h09999);
`ifdef BCD_SAT_EN
    chk("model_65535", 32'(model_conv(65535)), 32'h19999);
    chk("model_10000", 32'(model_conv(10000)), 32'h19999);
`else
    chk("model_65535", 32'(model_conv(65535)), 32'h15535);
    chk("model_10000", 32'(model_conv(10000)), 32'h10000);
`endif
    chk_en = 1'b1;

    // 1234: busy for 17 cycles, strobe for one cycle, value held afterwards
    send(16'd1234);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("t1_busy_cycles", 32'(n), 32'd17);
    chk("t1_strobe", 32'(we7), 32'd1);
    chk("t1_bcd", 32'(bcd), 32'h1234);
    chk("t1_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    chk("t1_strobe_len", 32'(we7), 32'd0);
    chk("t1_bcd_hold", 32'(bcd), 32'h1234);

    // 0 then 9999 back to back: strobes 18 clocks apart
    send(16'd0);
    wait_strobe("t2a");
    t1 = $time;
    chk("t2a_bcd", 32'(bcd), 32'h0000);
    we = 1'b1;
    d  = 16'd9999;
    @(negedge clk);
    we = 1'b0;
    wait_strobe("t2b");
    t2 = $time;
    chk("t2_period", 32'((t2 - t1) / 100), 32'd18);
    chk("t2b_bcd", 32'(bcd), 32'h9999);
    chk("t2b_ovf", 32'(ovf), 32'd0);

    // overflow
    send(16'd65535);
    wait_strobe("t3");
`ifdef BCD_SAT_EN
    chk("t3_bcd", 32'(bcd), 32'h9999);
`else
    chk("t3_bcd", 32'(bcd), 32'h5535);
`endif
    chk("t3_ovf", 32'(ovf), 32'd1);

    // writes while busy (+5) and in the DONE cycle (+17) are dropped
    @(negedge clk);
    s0 = dut_strobes;
    send(16'd42);
    repeat (4) @(negedge clk);
    we = 1'b1;
    d  = 16'd7;
    @(negedge clk);
    we = 1'b0;
    repeat (11) @(negedge clk);
    we = 1'b1;
    d  = 16'd7;
    @(negedge clk);
    we = 1'b0;
    chk("t4_strobe", 32'(we7), 32'd1);
    chk("t4_bcd", 32'(bcd), 32'h0042);
    chk("t4_ovf", 32'(ovf), 32'd0);
    repeat (30) @(negedge clk);
    chk("t4_strobe_count", 32'(dut_strobes - s0), 32'd1);
    chk("t4_idle", 32'(busy), 32'd0);

    // async reset mid-conversion aborts with no strobe
    send(16'd5000);
    repeat (7) @(negedge clk);
    #25 rst = 1'b1;
    #1;
    chk("t5_rst_bcd",  32'(bcd),  32'h0);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_ovf",  32'(ovf),  32'h0);
    chk("t5_rst_we7",  32'(we7),  32'h0);
    #10 rst = 1'b0;
    s0 = dut_strobes;
    repeat (25) @(negedge clk);
    chk("t5_no_strobe", 32'(dut_strobes - s0), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);
    send(16'd10);
    wait_strobe("t5b");
    chk("t5_bcd", 32'(bcd), 32'h0010);
    chk("t5_ovf", 32'(ovf), 32'd0);

    // random writes, many arriving while busy
    @(negedge clk);
    s0 = dut_strobes;
    a0 = m_accepts;
    cycles = 0;
    while ((m_accepts - a0) < 1000 && cycles < 40000) begin
      we = ($urandom_range(0, 3) != 0);
      d  = rand_val();
      @(negedge clk);
      cycles++;
    end
    we = 1'b0;
    chk("rand_budget", 32'(cycles < 40000), 32'd1);
    repeat (25) @(negedge clk);
    chk("rand_strobe_count", 32'(dut_strobes - s0), 32'(m_accepts - a0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
